instr_fetch_unit: RTL and testbench

//  Holds the PC and instruction register (IR) and runs the instruction-memory read handshake.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_pc_register.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM state
// encodings, opcode field width and the NOP word loaded into the IR on reset.
package instr_fetch_unit_pkg;

    localparam int FETCH_STATE_WIDTH  = 2;
    localparam int INSTR_OPCODE_WIDTH = 7;

    // RV32I "addi x0, x0, 0"
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        FETCH_STATE_IDLE = 2'b00,
        FETCH_STATE_REQ  = 2'b01,
        FETCH_STATE_WAIT = 2'b10
    } fetch_state_e;

    // A PC is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register for the fetch unit.
// Optional macro: FETCH_MISALIGN_TRAP_EN -- when defined, a write of a
// misaligned target leaves the PC unchanged and sets a sticky error flag;
// when undefined, the target is force-aligned and the error flag is tied low.
module instr_fetch_unit_pc_register
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [XLEN-1:0] pc_next_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_err_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_err_q;
    logic misalign_err_d;

    // Next PC: a misaligned target is rejected and flagged, an aligned one is taken.
    always_comb begin
        pc_d           = pc_q;
        misalign_err_d = misalign_err_q;
        if (we_i) begin
            if (is_misaligned(pc_next_i[1:0])) begin
                misalign_err_d = 1'b1;
            end else begin
                pc_d = pc_next_i;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and sticky misalignment flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            misalign_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign misalign_err_o = misalign_err_q;
`else
    // The low target bits are discarded by forced alignment.
    logic unused_low_bits_s;
    assign unused_low_bits_s = ^pc_next_i[1:0];

    // Next PC: the written target is aligned down to a word boundary.
    always_comb begin
        pc_d = pc_q;
        if (we_i) begin
            pc_d = {pc_next_i[XLEN-1:2], 2'b00};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign misalign_err_o = 1'b0;
`endif

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds PC and IR, runs the imem read handshake
// (REQ until accepted, WAIT until data or timeout) and stalls the controller
// while a fetch is in flight.
// Optional macro: FETCH_MISALIGN_TRAP_EN (see instr_fetch_unit_pc_register).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = {XLEN{1'b0}},
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PCWrite,
    input  logic                          IRWrite,
    input  logic [XLEN-1:0]               pcNext,
    output logic                          imemReq,
    output logic [XLEN-1:0]               imemAddr,
    input  logic                          imemReady,
    input  logic                          imemValid,
    input  logic [31:0]                   imemData,
    output logic [XLEN-1:0]               pc,
    output logic [31:0]                   instr,
    output logic [INSTR_OPCODE_WIDTH-1:0] opCode,
    output logic                          irValid,
    output logic                          stall,
    output logic                          fetchErr,
    output logic                          misalignErr
);

    // The counter compares against limit-1 so the error fires on the
    // TIMEOUT_CYCLES-th WAIT cycle without a valid response.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_e    state_q,     state_d;
    logic [XLEN-1:0] req_addr_q,  req_addr_d;
    logic [31:0]     instr_q,     instr_d;
    logic            ir_valid_q,  ir_valid_d;
    logic            fetch_err_q, fetch_err_d;
    logic [7:0]      tmo_cnt_q,   tmo_cnt_d;
    logic            imem_req_q,  imem_req_d;
    logic            stall_q,     stall_d;
    logic [XLEN-1:0] pc_s;

    instr_fetch_unit_pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk            (clk),
        .rst            (rst),
        .we_i           (PCWrite),
        .pc_next_i      (pcNext),
        .pc_o           (pc_s),
        .misalign_err_o (misalignErr)
    );

    // Fetch FSM next state, address latch, IR capture and timeout counting.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        instr_d     = instr_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        tmo_cnt_d   = tmo_cnt_q;
        imem_req_d  = 1'b0;
        stall_d     = 1'b0;
        case (state_q)
            FETCH_STATE_IDLE: begin
                if (IRWrite) begin
                    // Latch the PC before any same-edge PCWrite takes effect.
                    state_d    = FETCH_STATE_REQ;
                    req_addr_d = pc_s;
                    ir_valid_d = 1'b0;
                    imem_req_d = 1'b1;
                    stall_d    = 1'b1;
                end else begin
                    state_d = FETCH_STATE_IDLE;
                end
            end
            FETCH_STATE_REQ: begin
                stall_d = 1'b1;
                if (imemReady) begin
                    state_d    = FETCH_STATE_WAIT;
                    tmo_cnt_d  = 8'd0;
                    imem_req_d = 1'b0;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            FETCH_STATE_WAIT: begin
                if (imemValid) begin
                    state_d    = FETCH_STATE_IDLE;
                    instr_d    = imemData;
                    ir_valid_d = 1'b1;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    state_d     = FETCH_STATE_IDLE;
                    fetch_err_d = 1'b1;
                    ir_valid_d  = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    stall_d   = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_STATE_IDLE;
            end
        endcase
    end

    // Fetch state and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH_STATE_IDLE;
            req_addr_q  <= RESET_PC;
            instr_q     <= NOP_INSTR;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            tmo_cnt_q   <= 8'd0;
            imem_req_q  <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            instr_q     <= instr_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
            imem_req_q  <= imem_req_d;
            stall_q     <= stall_d;
        end
    end

    assign imemReq  = imem_req_q;
    assign imemAddr = req_addr_q;
    assign pc       = pc_s;
    assign instr    = instr_q;
    assign opCode   = instr_q[INSTR_OPCODE_WIDTH-1:0];
    assign irValid  = ir_valid_q;
    assign stall    = stall_q;
    assign fetchErr = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC=0x100,
// TIMEOUT_CYCLES=8). Inputs change and outputs are sampled 1ns after posedge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, PCWrite, IRWrite, imemReady, imemValid;
    logic [31:0] pcNext, imemData;
    logic        imemReq, irValid, stall, fetchErr, misalignErr;
    logic [31:0] imemAddr, pc, instr;
    logic [6:0]  opCode;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .XLEN           (32),
        .RESET_PC       (32'h0000_0100),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .pcNext      (pcNext),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemValid   (imemValid),
        .imemData    (imemData),
        .pc          (pc),
        .instr       (instr),
        .opCode      (opCode),
        .irValid     (irValid),
        .stall       (stall),
        .fetchErr    (fetchErr),
        .misalignErr (misalignErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PCWrite = 1'b0; IRWrite = 1'b0; pcNext = 32'h0;
        imemReady = 1'b0; imemValid = 1'b0; imemData = 32'h0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h100); end
        n_checks++; if (instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h13); end
        n_checks++; if (irValid !== 1'b0) begin n_fail++; $display("FAIL reset_irvalid: got %b expected 0", irValid); end
        n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imemReq); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imemAddr, 32'h100); end
        n_checks++; if (fetchErr !== 1'b0) begin n_fail++; $display("FAIL reset_fetcherr: got %b expected 0", fetchErr); end
        n_checks++; if (misalignErr !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalignErr); end
    endtask

    task automatic test_fast_fetch();
        IRWrite = 1'b1;
        tick();                                   // edge 1: IDLE -> REQ
        IRWrite = 1'b0;
        n_checks++; if (imemReq !== 1'b1) begin n_fail++; $display("FAIL fast_req: got %b expected 1", imemReq); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fast_stall: got %b expected 1", stall); end
        n_checks++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL fast_addr: got %h expected %h", imemAddr, 32'h100); end
        imemReady = 1'b1;
        tick();                                   // edge 2: REQ -> WAIT
        imemReady = 1'b0;
        n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL fast_req_drop: got %b expected 0", imemReq); end
        n_checks++; if (irValid !== 1'b0) begin n_fail++; $display("FAIL fast_irvalid_wait: got %b expected 0", irValid); end
        imemValid = 1'b1; imemData = 32'h0050_0093;
        tick();                                   // edge 3: capture
        imemValid = 1'b0;
        n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL fast_instr: got %h expected %h", instr, 32'h0050_0093); end
        n_checks++; if (irValid !== 1'b1) begin n_fail++; $display("FAIL fast_irvalid: got %b expected 1", irValid); end
        n_checks++; if (opCode !== 7'h13) begin n_fail++; $display("FAIL fast_opcode: got %h expected %h", opCode, 7'h13); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fast_stall_end: got %b expected 0", stall); end
    endtask

    task automatic test_slow_handshake();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        n_checks++; if (irValid !== 1'b0) begin n_fail++; $display("FAIL slow_irvalid_clr: got %b expected 0", irValid); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imemReq !== 1'b1) begin n_fail++; $display("FAIL slow_req_held[%0d]: got %b expected 1", i, imemReq); end
            n_checks++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL slow_addr[%0d]: got %h expected %h", i, imemAddr, 32'h100); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL slow_stall_req[%0d]: got %b expected 1", i, stall); end
            imemReady = (i == 3);
            // imemValid in REQ must be ignored
            imemValid = (i == 1);
            imemData  = 32'hDEAD_BEEF;
            tick();
        end
        imemReady = 1'b0; imemValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL slow_req_wait[%0d]: got %b expected 0", i, imemReq); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL slow_stall_wait[%0d]: got %b expected 1", i, stall); end
            n_checks++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL slow_addr_wait[%0d]: got %h expected %h", i, imemAddr, 32'h100); end
            tick();
        end
        imemValid = 1'b1; imemData = 32'h1234_5537;
        tick();
        imemValid = 1'b0;
        n_checks++; if (instr !== 32'h1234_5537) begin n_fail++; $display("FAIL slow_instr: got %h expected %h", instr, 32'h1234_5537); end
        n_checks++; if (opCode !== 7'h37) begin n_fail++; $display("FAIL slow_opcode: got %h expected %h", opCode, 7'h37); end
        n_checks++; if (irValid !== 1'b1) begin n_fail++; $display("FAIL slow_irvalid: got %b expected 1", irValid); end
    endtask

    task automatic test_pcwrite_during_wait();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0; imemReady = 1'b1;
        tick();                                   // now in WAIT
        imemReady = 1'b0;
        PCWrite = 1'b1; pcNext = 32'h104;
        tick();
        PCWrite = 1'b0;
        n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL wait_pc: got %h expected %h", pc, 32'h104); end
        n_checks++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL wait_addr: got %h expected %h", imemAddr, 32'h100); end
        IRWrite = 1'b1;                           // must be ignored while busy
        tick();
        IRWrite = 1'b0;
        n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL wait_irwrite_ignored: got %b expected 0", imemReq); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall: got %b expected 1", stall); end
        imemValid = 1'b1; imemData = 32'h0000_0063;
        tick();
        imemValid = 1'b0;
        n_checks++; if (instr !== 32'h0000_0063) begin n_fail++; $display("FAIL wait_instr: got %h expected %h", instr, 32'h0000_0063); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wait_done_stall: got %b expected 0", stall); end
    endtask

    task automatic test_same_edge();
        IRWrite = 1'b1; PCWrite = 1'b1; pcNext = 32'h108;
        tick();
        IRWrite = 1'b0; PCWrite = 1'b0;
        n_checks++; if (imemAddr !== 32'h104) begin n_fail++; $display("FAIL same_addr: got %h expected %h", imemAddr, 32'h104); end
        n_checks++; if (pc !== 32'h108) begin n_fail++; $display("FAIL same_pc: got %h expected %h", pc, 32'h108); end
        imemReady = 1'b1;
        tick();
        imemReady = 1'b0; imemValid = 1'b1; imemData = 32'h0000_0073;
        tick();
        imemValid = 1'b0;
        n_checks++; if (instr !== 32'h0000_0073) begin n_fail++; $display("FAIL same_instr: got %h expected %h", instr, 32'h0000_0073); end
    endtask

    task automatic test_timeout();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        n_checks++; if (imemAddr !== 32'h108) begin n_fail++; $display("FAIL tmo_addr: got %h expected %h", imemAddr, 32'h108); end
        imemReady = 1'b1;
        tick();                                   // WAIT entry
        imemReady = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++; if (fetchErr !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d]: got %b expected 0", i, fetchErr); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL tmo_stall[%0d]: got %b expected 1", i, stall); end
        end
        tick();                                   // 8th WAIT cycle
        n_checks++; if (fetchErr !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", fetchErr); end
        n_checks++; if (irValid !== 1'b0) begin n_fail++; $display("FAIL tmo_irvalid: got %b expected 0", irValid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL tmo_stall_end: got %b expected 0", stall); end
        n_checks++; if (instr !== 32'h0000_0073) begin n_fail++; $display("FAIL tmo_instr: got %h expected %h", instr, 32'h0000_0073); end
        // sticky across a later successful fetch
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0; imemReady = 1'b1;
        tick();
        imemReady = 1'b0; imemValid = 1'b1; imemData = 32'h0000_0013;
        tick();
        imemValid = 1'b0;
        n_checks++; if (fetchErr !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", fetchErr); end
        n_checks++; if (irValid !== 1'b1) begin n_fail++; $display("FAIL tmo_refetch: got %b expected 1", irValid); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_pc = 32'h108; exp_mis = 1'b1;
`else
        exp_pc = 32'h104; exp_mis = 1'b0;
`endif
        PCWrite = 1'b1; pcNext = 32'h106;
        tick();
        PCWrite = 1'b0;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", pc, exp_pc); end
        n_checks++; if (misalignErr !== exp_mis) begin n_fail++; $display("FAIL mis_flag: got %b expected %b", misalignErr, exp_mis); end
        PCWrite = 1'b1; pcNext = 32'hFFFF_FFFC;
        tick();
        PCWrite = 1'b0;
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mis_top_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
        n_checks++; if (misalignErr !== exp_mis) begin n_fail++; $display("FAIL mis_sticky: got %b expected %b", misalignErr, exp_mis); end
    endtask

    task automatic test_reset_midfetch();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0; imemReady = 1'b1;
        tick();
        imemReady = 1'b0; imemValid = 1'b1; imemData = 32'hCAFE_0033;
        rst = 1'b1;
        tick();
        rst = 1'b0; imemValid = 1'b0;
        n_checks++; if (instr !== 32'h13) begin n_fail++; $display("FAIL rstmid_instr: got %h expected %h", instr, 32'h13); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
        n_checks++; if (irValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_irvalid: got %b expected 0", irValid); end
        n_checks++; if (fetchErr !== 1'b0) begin n_fail++; $display("FAIL rstmid_fetcherr: got %b expected 0", fetchErr); end
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL rstmid_pc: got %h expected %h", pc, 32'h100); end
    endtask

    initial begin
        test_reset();
        test_fast_fetch();
        test_slow_handshake();
        test_pcwrite_during_wait();
        test_same_edge();
        test_timeout();
        test_misalign();
        test_reset_midfetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
